// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage. Owns the PC, runs a
// single-outstanding fetch handshake and drives the IF/ID register.
// A word returned while ID is stalled is parked in a hold buffer.
// A response to a fetch that was killed by a flush is dropped.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        cancel_q, cancel_d;
  logic [31:0] hold_q, hold_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        load_en;
  logic [31:0] load_word;

  // Next-state: fetch FSM first, then IF/ID update where flush wins over load and stall
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cancel_d   = cancel_q;
    hold_d     = hold_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    load_en    = 1'b0;
    load_word  = hold_q;

    case (state_q)
      S_REQ: begin
        // An accepted request in a flush cycle targets the old PC, so it is born cancelled
        if (inst_addr_ok) begin
          state_d  = S_WAIT;
          cancel_d = flush;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          cancel_d = 1'b0;
          if (cancel_q || flush) begin
            state_d = S_REQ;
          end else if (!stall) begin
            load_en   = 1'b1;
            load_word = inst_rdata;
            state_d   = S_REQ;
          end else begin
            hold_d  = inst_rdata;
            state_d = S_FULL;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      S_FULL: begin
        if (flush) begin
          state_d = S_REQ;
        end else if (!stall) begin
          load_en = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (flush) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP;
      pc_d       = redirect_pc;
    end else if (load_en) begin
      id_valid_d = 1'b1;
      id_pc_d    = pc_q;
      id_instr_d = load_word;
      pc_d       = pc_q + 32'd4;
    end else if (!stall) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      cancel_q   <= 1'b0;
      hold_q     <= 32'h0;
      id_valid_q <= 1'b0;
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cancel_q   <= cancel_d;
      hold_q     <= hold_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  // Request is combinational from state; it is suppressed while reset is held
  assign inst_req  = resetn && (state_q == S_REQ);
  assign inst_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC register, issues requests on a single-outstanding, SRAM-like instruction-memory handshake, and drives the IF/ID pipeline register. Consumes the hazard detection unit's stall (PC/IF-ID write hold) and flush (branch/jump redirect) outputs. Fetches delivered while ID is stalled are buffered, and responses to fetches cancelled by a flush are discarded.

## Interface
- RESET_PC, 32'hBFC0_0000, PC fetched first after reset
- NOP, 32'h0000_0000, instruction word loaded into IF/ID as a bubble
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- stall  in  1  hazard-unit hold; 1 = PC and IF/ID must not advance
- flush  in  1  hazard-unit redirect; 1 = kill IF/ID content and in-flight fetch, refetch from redirect_pc
- redirect_pc  in  32  branch/jump target, sampled only when flush=1
- inst_req  out  1  fetch request valid
- inst_addr  out  32  fetch address, equals internal pc
- inst_addr_ok  in  1  memory accepted the request this cycle (meaningful only while inst_req=1)
- inst_rdata  in  32  fetched word, valid with inst_data_ok
- inst_data_ok  in  1  response for the single outstanding request
- id_valid  out  1  IF/ID holds a real instruction
- id_pc  out  32  PC of id_instr
- id_instr  out  32  IF/ID instruction word

## Operation
- State: pc[31:0], FSM {S_REQ, S_WAIT, S_FULL}, cancel flag, 32-bit hold buffer, IF/ID register (id_valid, id_pc, id_instr).
- At most one request outstanding. Memory never asserts inst_data_ok without an accepted request.
- S_REQ: inst_req=1, inst_addr=pc.
  - Without addr_ok, hold; the address remains stable unless flush.
  - On addr_ok: go to S_WAIT.
- S_WAIT: inst_req=0. On data_ok:
  - cancel=1: discard the word, clear cancel, go to S_REQ.
  - else stall=0: IF/ID <= {1, pc, inst_rdata}, pc <= pc+4, go to S_REQ.
  - else stall=1: buffer <= inst_rdata, go to S_FULL.
- S_FULL: inst_req=0. When stall=0: IF/ID <= {1, pc, buffer}, pc <= pc+4, go to S_REQ.
- IF/ID when not loaded in a cycle:
  - stall=1: holds.
  - stall=0: becomes a bubble {0, id_pc unchanged, NOP}.
- flush has priority over stall and over any load:
  - IF/ID <= bubble; pc <= redirect_pc; buffer dropped.
  - S_REQ with addr_ok that cycle: go to S_WAIT with cancel=1.
  - S_REQ without addr_ok: stay in S_REQ; next cycle inst_addr=redirect_pc.
  - S_WAIT without data_ok: cancel <= 1, stay in S_WAIT.
  - S_WAIT with data_ok: discard the word, cancel <= 0, go to S_REQ.
  - S_FULL: go to S_REQ.
- pc+4 wraps modulo 2^32. redirect_pc is used unaligned as given; alignment checking is not this block's job.

## Timing
- Reset (resetn=0 at edge): pc=RESET_PC, state=S_REQ, cancel=0, id_valid=0, id_pc=0, id_instr=NOP.
  - inst_req is forced to 0 while resetn=0.
  - Outputs are combinational from state, so inst_req=1 with inst_addr=RESET_PC in the first cycle after release.
- Best case (addr_ok in the request cycle, data_ok the next cycle): instruction visible in IF/ID 2 cycles after request start. Throughput is 1 instruction per 2 cycles.
- Flush in cycle t: IF/ID shows a bubble at t+1. The earliest request to redirect_pc is at t+1; if a cancelled response is still pending, the request follows its data_ok.
- Reset asserted mid-transaction returns to the reset state. Memory is reset on the same resetn, so no stale data_ok follows.
- stall and flush are sampled every cycle and require no setup beyond the same edge.

## Test plan
- Reset then free-run, addr_ok=1 every request, data_ok one cycle later: inst_addr sequence BFC00000, BFC00004, BFC00008; id_pc follows with id_valid=1 every other cycle and bubbles in between.
- data_ok arrives while stall=1 for 3 cycles: state goes to S_FULL; IF/ID holds its prior value; on stall release the buffered word appears with the correct id_pc and the next request uses pc+4.
- Flush with redirect_pc=0x80001000 while in S_WAIT, data_ok 2 cycles later: the stale word never reaches IF/ID; the next request address is 0x80001000.
- Flush and data_ok in the same cycle, with stall=1 also asserted: IF/ID becomes a bubble (id_valid=0, id_instr=0); no S_FULL entry; next request is redirect_pc.
- addr_ok withheld for 4 cycles: inst_req and inst_addr stay stable; a flush in cycle 3 changes inst_addr to redirect_pc in cycle 4.
- pc=0xFFFFFFFC fetched normally: the next inst_addr is 0x00000000. resetn pulled low in S_WAIT: all outputs return to their reset values at the next edge.
